// File: rtl/cla_sub_pkg.sv
// Shared types and sizing helpers for the chunked carry-lookahead subtractor.
package cla_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Keep the chunk counter at least one bit wide even for a single-chunk build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_CHUNK  = 4;
  localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int DEF_CNT_W  = cnt_width(DEF_NCHUNK);

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead adder slice (generate/propagate form).
module cla_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = carry_in;

  // Each carry is a flat sum of products over lower g/p terms, not a ripple chain.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_carry
    logic lc;
    logic pp;
    always_comb begin
      lc = g[gi];
      pp = p[gi];
      for (int j = gi - 1; j >= 0; j--) begin
        lc = lc | (pp & g[j]);
        pp = pp & p[j];
      end
      lc = lc | (pp & carry_in);
    end
    assign c[gi+1] = lc;
  end

  assign sum       = p ^ c[CHUNK-1:0];
  assign carry_out = c[CHUNK];

endmodule

// File: rtl/cla_chunk_subtractor.sv
// Multi-cycle a - b - borrow_in: one CLA slice reused over WIDTH/CHUNK clocks,
// with the carry held in a register between chunks.
module cla_chunk_subtractor
  import cla_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("cla_chunk_subtractor: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] k_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] nb_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;

  assign in_ready = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  cla_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a        (a_reg[k_reg*CHUNK +: CHUNK]),
    .b        (nb_reg[k_reg*CHUNK +: CHUNK]),
    .carry_in (carry_reg),
    .sum      (slice_sum),
    .carry_out(slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      a_reg         <= '0;
      nb_reg        <= '0;
      carry_reg     <= 1'b0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      // Subtraction as a + ~b + ~borrow_in.
      a_reg         <= a;
      nb_reg        <= ~b;
      carry_reg     <= ~borrow_in;
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      state_reg     <= RUN;
    end else begin
      case (state_reg)
        RUN: begin
          diff_reg[k_reg*CHUNK +: CHUNK] <= slice_sum;
          carry_reg <= slice_cout;
          if (k_reg == LAST_K) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            borrow_reg    <= ~slice_cout;
            // nb_reg holds ~b, so equal MSBs here mean a and b differ in sign.
            ovf_reg       <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &
                             (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
          end else begin
            k_reg <= k_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;
  assign overflow   = ovf_reg;

endmodule
